ex_mem_skid_reg: RTL and testbench
==================================

EX_MEM_SKID_REG -- requirements
Module: ex_mem_skid_reg

Interface
REQ-001 SHALL have parameter XLEN, default 32, data path width of ALU result and store data.
REQ-002 SHALL have parameter RA_W, default 5, destination register address width.
REQ-003 SHALL have parameter SKID_EN, default 1; 1 = two-entry skid buffer, 0 = single register with combinational ready.
REQ-004 SHALL have one clock and an asynchronous, active-low reset: clk input 1 rising-edge clock; rst_n input 1 async active-low reset.
REQ-005 SHALL have ports s_valid in 1 EX result valid; s_ready out 1 stage can accept.
REQ-006 SHALL have ports alu_in in XLEN ALU result / effective address; rd_addr_in in RA_W destination; rs2_data_in in XLEN store source; wr_en_in in 1 register writeback.
REQ-007 SHALL have port mem_op_in in 4: 0 none, 1 LB, 2 LH, 3 LW, 4 LBU, 5 LHU, 8 SB, 9 SH, 10 SW; other codes illegal.
REQ-008 SHALL have port flush in 1, which kills all held and incoming entries.
REQ-009 SHALL have ports m_valid out 1; m_ready in 1 MEM stage accept.
REQ-010 SHALL have outputs alu_out XLEN; rd_addr_out RA_W; wr_en_out 1.
REQ-011 SHALL have outputs rs2_data_out XLEN, lane-replicated store data; byte_en_out XLEN/8, store byte mask.
REQ-012 SHALL have outputs load_en_out, str_en_out, lb/lh/lw/lbu/lhu_en_out, sb/sh/sw_en_out, 1 each, one-hot decoded mem op.
REQ-013 SHALL have output misalign_out 1: access not naturally aligned, or illegal op.

Function
REQ-014 SHALL transfer on input when s_valid&&s_ready and on output when m_valid&&m_ready.
REQ-015 SHALL present an accepted entry on outputs the cycle after acceptance (latency 1) when the buffer was empty.
REQ-016 SHALL (SKID_EN=1) drive s_ready from a register only: s_ready=0 exactly when both entries are held.
REQ-017 SHALL, when the output stalls (m_valid&&!m_ready) with one entry held and input accepted, store input in the skid entry and keep outputs stable.
REQ-018 SHALL drain the skid entry to the output entry on the next output transfer, preserving order; no entry lost or duplicated.
REQ-019 SHALL (SKID_EN=0) give s_ready = !m_valid || m_ready.
REQ-020 SHALL hold every output stable while m_valid&&!m_ready.
REQ-021 SHALL, on flush, empty both entries next edge: m_valid=0, s_ready=1; a same-cycle s_valid is dropped; flush overrides m_ready.
REQ-022 SHALL force wr_en_out=0 when rd_addr_out==0.
REQ-023 SHALL compute byte_en_out from alu_out[1:0]: SB 1<<a; SH 4'b0011<<a; SW 4'b1111; loads/none 0.
REQ-024 SHALL replicate store data: SB {4{rs2[7:0]}}, SH {2{rs2[15:0]}}, SW rs2; otherwise rs2 unchanged.
REQ-025 SHALL assert misalign_out for LH/LHU/SH with a[0]=1, LW/SW with a[1:0]!=0, or illegal op; then all strobes and byte_en_out are 0 and wr_en_out=0.
REQ-026 SHALL set load_en_out = lb|lh|lw|lbu|lhu and str_en_out = sb|sh|sw.

Reset
REQ-027 SHALL, while rst_n=0, clear both entries: m_valid=0, all strobes, byte_en_out, misalign_out, wr_en_out 0, data outputs 0.
REQ-028 SHALL drive s_ready=1 from the first edge after rst_n deasserts; reset mid-transfer discards held entries.

Structure
REQ-029 SHALL take mem_op encodings and widths from the shared core package/include used by decode and MEM stages.
REQ-030 SHALL instantiate one sub-module mem_op_decode (combinational: mem_op, addr[1:0], rs2 -> strobes, byte_en, aligned data, misalign).

Verification
REQ-031 SHALL check SW alu=0x1000 rs2=0xDEADBEEF rd=5, m_ready=1 -> next cycle m_valid=1, byte_en=0xF, sw_en=1, str_en=1, wr_en=1.
REQ-032 SHALL check SB alu=0x1003 rs2=0x000000AB -> byte_en=0x8, rs2_data_out=0xABABABAB.
REQ-033 SHALL check LW alu=0x1002 -> misalign_out=1, lw_en=0, load_en=0, wr_en=0.
REQ-034 SHALL check m_ready=0 while sending A,B -> s_ready=0 after B; release -> A then B in order, no loss.
REQ-035 SHALL check flush with two entries held and s_valid=1 -> next cycle m_valid=0, s_ready=1, no entry appears later.
REQ-036 SHALL check rd_addr_in=0 with wr_en_in=1 -> wr_en_out=0; rst_n low mid-stall -> m_valid=0 immediately.

Source files
------------

// File: rtl/ex_mem_skid_reg_pkg.sv
// Shared core memory-op encodings, used by decode, EX/MEM boundary and MEM stages.
package ex_mem_skid_reg_pkg;

  localparam int MEM_OP_W = 4;

  typedef enum logic [MEM_OP_W-1:0] {
    MOP_NONE = 4'd0,
    MOP_LB   = 4'd1,
    MOP_LH   = 4'd2,
    MOP_LW   = 4'd3,
    MOP_LBU  = 4'd4,
    MOP_LHU  = 4'd5,
    MOP_SB   = 4'd8,
    MOP_SH   = 4'd9,
    MOP_SW   = 4'd10
  } mem_op_t;

endpackage

// File: rtl/ex_mem_skid_reg_mem_op_decode.sv
// Combinational memory-op decode: one-hot strobes, store byte mask, lane-replicated
// store data and alignment check. A misaligned or illegal op suppresses every strobe.
module mem_op_decode
  import ex_mem_skid_reg_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [MEM_OP_W-1:0] mem_op,
  input  logic [1:0]          addr,
  input  logic [XLEN-1:0]     rs2,
  output logic                lb_en,
  output logic                lh_en,
  output logic                lw_en,
  output logic                lbu_en,
  output logic                lhu_en,
  output logic                sb_en,
  output logic                sh_en,
  output logic                sw_en,
  output logic                load_en,
  output logic                str_en,
  output logic [XLEN/8-1:0]   byte_en,
  output logic [XLEN-1:0]     store_data,
  output logic                misalign
);

  logic [3:0] be4;

  always_comb begin
    lb_en      = 1'b0;
    lh_en      = 1'b0;
    lw_en      = 1'b0;
    lbu_en     = 1'b0;
    lhu_en     = 1'b0;
    sb_en      = 1'b0;
    sh_en      = 1'b0;
    sw_en      = 1'b0;
    be4        = 4'b0000;
    misalign   = 1'b0;
    store_data = rs2;
    case (mem_op)
      MOP_NONE: ;
      MOP_LB:   lb_en = 1'b1;
      MOP_LBU:  lbu_en = 1'b1;
      MOP_LH:   begin lh_en  = 1'b1; misalign = addr[0]; end
      MOP_LHU:  begin lhu_en = 1'b1; misalign = addr[0]; end
      MOP_LW:   begin lw_en  = 1'b1; misalign = |addr;   end
      MOP_SB: begin
        sb_en      = 1'b1;
        be4        = 4'b0001 << addr;
        store_data = {(XLEN/8){rs2[7:0]}};
      end
      MOP_SH: begin
        sh_en      = 1'b1;
        be4        = 4'b0011 << addr;
        misalign   = addr[0];
        store_data = {(XLEN/16){rs2[15:0]}};
      end
      MOP_SW: begin
        sw_en    = 1'b1;
        be4      = 4'b1111;
        misalign = |addr;
      end
      default:  misalign = 1'b1;
    endcase
    // A trapping access must not touch memory or the register file.
    if (misalign) begin
      {lb_en, lh_en, lw_en, lbu_en, lhu_en, sb_en, sh_en, sw_en} = 8'h00;
      be4 = 4'b0000;
    end
    load_en = lb_en | lh_en | lw_en | lbu_en | lhu_en;
    str_en  = sb_en | sh_en | sw_en;
    byte_en = '0;
    byte_en[3:0] = be4;
  end

endmodule

// File: rtl/ex_mem_skid_reg.sv
// EX/MEM pipeline register with optional two-entry skid buffer; latency 1 when empty.
// With SKID_EN=1 s_ready is a pure register output, so no comb path from m_ready.
module ex_mem_skid_reg
  import ex_mem_skid_reg_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int RA_W    = 5,
  parameter int SKID_EN = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                s_valid,
  output logic                s_ready,
  input  logic [XLEN-1:0]     alu_in,
  input  logic [RA_W-1:0]     rd_addr_in,
  input  logic [XLEN-1:0]     rs2_data_in,
  input  logic                wr_en_in,
  input  logic [MEM_OP_W-1:0] mem_op_in,
  input  logic                flush,
  output logic                m_valid,
  input  logic                m_ready,
  output logic [XLEN-1:0]     alu_out,
  output logic [RA_W-1:0]     rd_addr_out,
  output logic                wr_en_out,
  output logic [XLEN-1:0]     rs2_data_out,
  output logic [XLEN/8-1:0]   byte_en_out,
  output logic                load_en_out,
  output logic                str_en_out,
  output logic                lb_en_out,
  output logic                lh_en_out,
  output logic                lw_en_out,
  output logic                lbu_en_out,
  output logic                lhu_en_out,
  output logic                sb_en_out,
  output logic                sh_en_out,
  output logic                sw_en_out,
  output logic                misalign_out
);

  typedef struct packed {
    logic [XLEN-1:0]     alu;
    logic [XLEN-1:0]     rs2;
    logic [RA_W-1:0]     rd;
    logic                wr_en;
    logic [MEM_OP_W-1:0] mem_op;
  } entry_t;

  entry_t in_ent, out_q, out_d, skid_q, skid_d;
  logic   out_vld_q, out_vld_d, skid_vld_q, skid_vld_d, ready_q, in_fire;

  assign in_ent  = '{alu: alu_in, rs2: rs2_data_in, rd: rd_addr_in,
                     wr_en: wr_en_in, mem_op: mem_op_in};
  assign s_ready = (SKID_EN != 0) ? ready_q : (!out_vld_q || m_ready);
  assign in_fire = s_valid && s_ready;

  // The skid entry only fills while the output is stalled, so it is always the younger one.
  always_comb begin
    out_d      = out_q;
    skid_d     = skid_q;
    out_vld_d  = out_vld_q;
    skid_vld_d = skid_vld_q;
    if (flush) begin
      out_vld_d  = 1'b0;
      skid_vld_d = 1'b0;
    end else if (!out_vld_q || m_ready) begin
      if (skid_vld_q) begin
        out_d      = skid_q;
        out_vld_d  = 1'b1;
        skid_vld_d = 1'b0;
      end else begin
        out_vld_d = in_fire;
        if (in_fire) out_d = in_ent;
      end
    end else if (in_fire) begin
      skid_d     = in_ent;
      skid_vld_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q      <= '0;
      skid_q     <= '0;
      out_vld_q  <= 1'b0;
      skid_vld_q <= 1'b0;
      ready_q    <= 1'b0;
    end else begin
      out_q      <= out_d;
      skid_q     <= skid_d;
      out_vld_q  <= out_vld_d;
      skid_vld_q <= skid_vld_d;
      ready_q    <= !skid_vld_d;
    end
  end

  mem_op_decode #(.XLEN(XLEN)) u_dec (
    .mem_op     (out_q.mem_op),
    .addr       (out_q.alu[1:0]),
    .rs2        (out_q.rs2),
    .lb_en      (lb_en_out),
    .lh_en      (lh_en_out),
    .lw_en      (lw_en_out),
    .lbu_en     (lbu_en_out),
    .lhu_en     (lhu_en_out),
    .sb_en      (sb_en_out),
    .sh_en      (sh_en_out),
    .sw_en      (sw_en_out),
    .load_en    (load_en_out),
    .str_en     (str_en_out),
    .byte_en    (byte_en_out),
    .store_data (rs2_data_out),
    .misalign   (misalign_out)
  );

  assign m_valid     = out_vld_q;
  assign alu_out     = out_q.alu;
  assign rd_addr_out = out_q.rd;
  assign wr_en_out   = out_q.wr_en && (out_q.rd != '0) && !misalign_out;

endmodule

// File: tb/tb_ex_mem_skid_reg.sv
// Directed bench for ex_mem_skid_reg: decode vectors, backpressure ordering, flush, reset.
module tb_ex_mem_skid_reg;

  logic        clk, rst_n;
  logic        s_valid, s_ready, flush, m_valid, m_ready;
  logic [31:0] alu_in, rs2_data_in, alu_out, rs2_data_out;
  logic [4:0]  rd_addr_in, rd_addr_out;
  logic        wr_en_in, wr_en_out;
  logic [3:0]  mem_op_in, byte_en_out;
  logic        load_en_out, str_en_out, lb_en_out, lh_en_out, lw_en_out, lbu_en_out;
  logic        lhu_en_out, sb_en_out, sh_en_out, sw_en_out, misalign_out;

  int checks = 0;
  int failures = 0;

  ex_mem_skid_reg #(.XLEN(32), .RA_W(5), .SKID_EN(1)) dut (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready),
    .alu_in(alu_in), .rd_addr_in(rd_addr_in), .rs2_data_in(rs2_data_in),
    .wr_en_in(wr_en_in), .mem_op_in(mem_op_in), .flush(flush),
    .m_valid(m_valid), .m_ready(m_ready), .alu_out(alu_out),
    .rd_addr_out(rd_addr_out), .wr_en_out(wr_en_out), .rs2_data_out(rs2_data_out),
    .byte_en_out(byte_en_out), .load_en_out(load_en_out), .str_en_out(str_en_out),
    .lb_en_out(lb_en_out), .lh_en_out(lh_en_out), .lw_en_out(lw_en_out),
    .lbu_en_out(lbu_en_out), .lhu_en_out(lhu_en_out), .sb_en_out(sb_en_out),
    .sh_en_out(sh_en_out), .sw_en_out(sw_en_out), .misalign_out(misalign_out)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] alu, input logic [31:0] rs2,
                       input logic [4:0] rd, input logic wr, input logic [3:0] op);
    s_valid     = 1'b1;
    alu_in      = alu;
    rs2_data_in = rs2;
    rd_addr_in  = rd;
    wr_en_in    = wr;
    mem_op_in   = op;
  endtask

  initial begin
    rst_n = 1'b0; s_valid = 1'b0; flush = 1'b0; m_ready = 1'b1;
    alu_in = '0; rs2_data_in = '0; rd_addr_in = '0; wr_en_in = 1'b0; mem_op_in = '0;
    #12;
    chk("rst_m_valid", m_valid, 0);
    chk("rst_byte_en", byte_en_out, 0);
    chk("rst_alu_out", alu_out, 0);
    chk("rst_wr_en", wr_en_out, 0);
    chk("rst_misalign", misalign_out, 0);
    chk("rst_str_en", str_en_out, 0);
    rst_n = 1'b1;
    tick();
    chk("post_rst_s_ready", s_ready, 1);

    // SW aligned
    drive(32'h1000, 32'hDEADBEEF, 5'd5, 1'b1, 4'd10);
    tick(); s_valid = 1'b0;
    chk("sw_m_valid", m_valid, 1);
    chk("sw_byte_en", byte_en_out, 4'hF);
    chk("sw_en", sw_en_out, 1);
    chk("sw_str_en", str_en_out, 1);
    chk("sw_wr_en", wr_en_out, 1);
    chk("sw_data", rs2_data_out, 32'hDEADBEEF);

    // SB top byte
    drive(32'h1003, 32'h000000AB, 5'd6, 1'b0, 4'd8);
    tick(); s_valid = 1'b0;
    chk("sb_byte_en", byte_en_out, 4'h8);
    chk("sb_data", rs2_data_out, 32'hABABABAB);
    chk("sb_en", sb_en_out, 1);

    // SH upper half
    drive(32'h1002, 32'h1234CDEF, 5'd6, 1'b0, 4'd9);
    tick(); s_valid = 1'b0;
    chk("sh_byte_en", byte_en_out, 4'hC);
    chk("sh_data", rs2_data_out, 32'hCDEFCDEF);

    // LW misaligned
    drive(32'h1002, 32'h0, 5'd7, 1'b1, 4'd3);
    tick(); s_valid = 1'b0;
    chk("lw_mis_misalign", misalign_out, 1);
    chk("lw_mis_lw_en", lw_en_out, 0);
    chk("lw_mis_load_en", load_en_out, 0);
    chk("lw_mis_wr_en", wr_en_out, 0);

    // LBU at odd address is fine
    drive(32'h1001, 32'h0, 5'd3, 1'b1, 4'd4);
    tick(); s_valid = 1'b0;
    chk("lbu_en", lbu_en_out, 1);
    chk("lbu_load_en", load_en_out, 1);
    chk("lbu_wr_en", wr_en_out, 1);
    chk("lbu_misalign", misalign_out, 0);
    chk("lbu_byte_en", byte_en_out, 0);

    // Illegal op code 6
    drive(32'h1000, 32'h0, 5'd3, 1'b1, 4'd6);
    tick(); s_valid = 1'b0;
    chk("illegal_misalign", misalign_out, 1);
    chk("illegal_wr_en", wr_en_out, 0);

    // Writeback to x0 suppressed
    drive(32'h1000, 32'h0, 5'd0, 1'b1, 4'd3);
    tick(); s_valid = 1'b0;
    chk("rd0_wr_en", wr_en_out, 0);
    chk("rd0_lw_en", lw_en_out, 1);
    tick();
    chk("drained_m_valid", m_valid, 0);

    // Backpressure: A then B held, released in order
    m_ready = 1'b0;
    drive(32'h0000_00A0, 32'h0, 5'd1, 1'b1, 4'd0);
    tick();
    chk("bp_a_m_valid", m_valid, 1);
    chk("bp_a_s_ready", s_ready, 1);
    drive(32'h0000_00B0, 32'h0, 5'd2, 1'b1, 4'd0);
    tick(); s_valid = 1'b0;
    chk("bp_full_s_ready", s_ready, 0);
    chk("bp_hold_alu_a", alu_out, 32'hA0);
    tick();
    chk("bp_stable_alu_a", alu_out, 32'hA0);
    chk("bp_stable_rd_a", rd_addr_out, 1);
    m_ready = 1'b1;
    tick();
    chk("bp_rel_alu_b", alu_out, 32'hB0);
    chk("bp_rel_rd_b", rd_addr_out, 2);
    chk("bp_rel_m_valid", m_valid, 1);
    chk("bp_rel_s_ready", s_ready, 1);
    tick();
    chk("bp_done_m_valid", m_valid, 0);

    // Flush with two held entries and an incoming one
    m_ready = 1'b0;
    drive(32'h0000_00C0, 32'h0, 5'd1, 1'b1, 4'd0);
    tick();
    drive(32'h0000_00D0, 32'h0, 5'd2, 1'b1, 4'd0);
    tick();
    chk("fl_full_s_ready", s_ready, 0);
    drive(32'h0000_00E0, 32'h0, 5'd3, 1'b1, 4'd0);
    flush = 1'b1;
    tick();
    flush = 1'b0; s_valid = 1'b0; m_ready = 1'b1;
    chk("fl_m_valid", m_valid, 0);
    chk("fl_s_ready", s_ready, 1);
    tick();
    chk("fl_later1_m_valid", m_valid, 0);
    tick();
    chk("fl_later2_m_valid", m_valid, 0);

    // Reset while stalled
    m_ready = 1'b0;
    drive(32'h0000_00F0, 32'h0, 5'd4, 1'b1, 4'd10);
    tick(); s_valid = 1'b0;
    chk("rs_m_valid_before", m_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("rs_m_valid_now", m_valid, 0);
    chk("rs_alu_out_now", alu_out, 0);
    #2;
    rst_n = 1'b1;
    tick();
    chk("rs_s_ready_after", s_ready, 1);
    chk("rs_m_valid_after", m_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
